// File: rtl/ucsbece154b_dmem_responder_pkg.sv
// rtl/ucsbece154b_dmem_responder_pkg.sv - shared types and constants for the data-memory responder
//
// Contents:
//   dmem_state_e   : responder FSM state encoding (IDLE / WAIT / RESP)
//   DMEM_BASE_ADDR : default byte address of data-memory word 0
//   PC_START       : reset program counter of the pipeline (kept beside the data base)
//   dmem_addr_err  : address check shared by the responder

package ucsbece154b_dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h1000_0000;
    localparam logic [31:0] PC_START       = 32'h0001_0000;

    // Misaligned, or offset from base beyond the array. The offset is taken
    // modulo 2^32, so addresses below base wrap to huge offsets and fail too.
    function automatic logic dmem_addr_err(
        input logic [31:0] addr,
        input logic [31:0] offset,
        input logic [32:0] limit_bytes
    );
        return (addr[1:0] != 2'b00) || ({1'b0, offset} >= limit_bytes);
    endfunction

endpackage

// File: rtl/ucsbece154b_dmem_array.sv
// rtl/ucsbece154b_dmem_array.sv - word storage with byte-lane write and asynchronous read
//
// Ports:
//   clk       : rising-edge clock for the write port
//   i_commit  : write strobe; lanes selected by i_be are updated on the edge
//   i_index   : word index (shared by read and write)
//   i_wdata   : write data
//   i_be      : byte-lane enables, bit n covers bits [8n+7:8n]
//   o_rdata   : current contents of word i_index (combinational)

module ucsbece154b_dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_commit,
    input  logic [AW-1:0] i_index,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_be,
    output logic [31:0]   o_rdata
);

    // Contents are deliberately not reset: a reset only aborts transactions.
    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_index][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_index];

endmodule

// File: rtl/ucsbece154b_dmem_responder.sv
// rtl/ucsbece154b_dmem_responder.sv - latency-injecting data-memory responder for the Memory stage
//
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   req_*         : request channel (valid/ready), we, byte address, wdata, byte enables
//   resp_*        : response channel (valid/ready), read data, error flag
//   busy_o        : a transaction is in flight (WAIT or RESP)

module ucsbece154b_dmem_responder
    import ucsbece154b_dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        busy_o
);

    localparam int unsigned AW          = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_LOAD    = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic        NO_WAIT     = (WAIT_CYCLES == 0);

    dmem_state_e r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_resp_valid;
    logic [31:0] r_rdata;
    logic        r_err;

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_we;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [3:0]    w_be;
    logic [31:0]   w_offset;
    logic          w_err;
    logic [AW-1:0] w_index;
    logic          w_commit;
    logic [31:0]   w_mem_rdata;

    assign w_accept     = (r_state == ST_IDLE) && req_valid_i;
    assign w_enter_resp = (w_accept && NO_WAIT) || ((r_state == ST_WAIT) && (r_cnt == 4'd0));

    // With no wait states the commit edge is the acceptance edge, so the
    // array must see the live request instead of the captured copy.
    assign w_we    = (r_state == ST_IDLE) ? req_we_i    : r_we;
    assign w_addr  = (r_state == ST_IDLE) ? req_addr_i  : r_addr;
    assign w_wdata = (r_state == ST_IDLE) ? req_wdata_i : r_wdata;
    assign w_be    = (r_state == ST_IDLE) ? req_be_i    : r_be;

    assign w_offset = w_addr - BASE_ADDR;
    assign w_err    = dmem_addr_err(w_addr, w_offset, LIMIT_BYTES);
    assign w_index  = w_offset[AW+1:2];
    assign w_commit = w_enter_resp && w_we && !w_err;

    ucsbece154b_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk      (clk),
        .i_commit (w_commit),
        .i_index  (w_index),
        .i_wdata  (w_wdata),
        .i_be     (w_be),
        .o_rdata  (w_mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_be         <= 4'd0;
            r_resp_valid <= 1'b0;
            r_rdata      <= 32'd0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_we    <= req_we_i;
                        r_addr  <= req_addr_i;
                        r_wdata <= req_wdata_i;
                        r_be    <= req_be_i;
                        r_cnt   <= CNT_LOAD;
                        r_state <= NO_WAIT ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Response payload is latched once, on entry to RESP, and then
            // held untouched until the handshake completes.
            if (w_enter_resp) begin
                r_resp_valid <= 1'b1;
                r_rdata      <= (w_we || w_err) ? 32'd0 : w_mem_rdata;
                r_err        <= w_err;
            end
        end
    end

    assign req_ready_o  = (r_state == ST_IDLE);
    assign busy_o       = (r_state != ST_IDLE);
    assign resp_valid_o = r_resp_valid;
    assign resp_rdata_o = r_rdata;
    assign resp_err_o   = r_err;

endmodule

// File: doc/ucsbece154b_dmem_responder.md
Name: ucsbece154b_dmem_responder

Overview:
- Data-memory responder (target side) for the pipeline's Memory-stage data port.
- Accepts one word request at a time (read or byte-masked write) over a valid/ready request channel.
- Waits a configurable number of cycles, then returns read data or a write acknowledgement over a valid/ready response channel.
- Used in place of the zero-latency data memory, to exercise stall logic under realistic memory latency.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; power of two, at least 2.
- WAIT_CYCLES, 2, idle cycles between request acceptance and response; 0 to 15.
- BASE_ADDR, 32'h10000000, byte address of word 0; word aligned.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  responder can accept a request.
- req_we_i  input  1  1 = write, 0 = read.
- req_addr_i  input  32  byte address (ALUResultM).
- req_wdata_i  input  32  write data (WriteDataM).
- req_be_i  input  4  byte-lane write enables; bit n covers bits [8n+7:8n].
- resp_valid_o  output  1  response present.
- resp_ready_i  input  1  requester accepts the response.
- resp_rdata_o  output  32  read data; 0 for writes and errors.
- resp_err_o  output  1  request was misaligned or out of range.
- busy_o  output  1  a request is in flight (state is not IDLE).

Behaviour:
- Reset (reset low, asynchronous): state IDLE, wait counter 0, resp_valid_o 0, resp_rdata_o 0, resp_err_o 0, busy_o 0.
- Reset while in IDLE: req_ready_o 1.
- Reset does not clear storage contents.
- Reset mid-operation aborts the transaction. A write that has not yet reached RESP is not committed.
- FSM states:
  - IDLE: req_ready_o 1. On req_valid_i, capture addr/we/wdata/be. Go to WAIT if WAIT_CYCLES > 0, else go to RESP. Load counter with WAIT_CYCLES-1.
  - WAIT: req_ready_o 0. Counter decrements each cycle. When counter is 0 on a clock edge, go to RESP.
  - RESP: resp_valid_o 1. Outputs are held stable until resp_ready_i. When resp_valid_o and resp_ready_i are both 1 on an edge, go to IDLE.
- Handshake rules:
  - Only one transaction is outstanding at a time.
  - req_ready_o is 0 outside IDLE, so a new request is never accepted in the same cycle a response completes.
  - resp_valid_o must not drop before acceptance.
- Latency:
  - Acceptance edge to first cycle of resp_valid_o is WAIT_CYCLES+1 cycles.
  - Minimum repeat interval is WAIT_CYCLES+2 cycles, with resp_ready_i held 1.
- Commit: the write and the read-data capture both happen on the edge that enters RESP.
  - Read data is registered and never changes while in RESP.
- Address decode:
  - offset = req_addr - BASE_ADDR, modulo 2^32.
  - index = offset[clog2(DEPTH_WORDS)+1:2].
  - Error if addr[1:0] != 0, or if offset >= DEPTH_WORDS*4. Wrap-around below BASE_ADDR yields a large offset and is therefore an error.
- On error: no write, resp_rdata_o 0, resp_err_o 1. The response path is otherwise identical.
- Write with req_be_i 4'b0000: no storage change, normal acknowledgement, err 0.
- Write: lanes with be bit 0 keep their old bytes.
- Read: req_be_i is ignored and the full word is returned.
- busy_o is 1 in WAIT and RESP.

Decomposition:
- Shared package/include:
  - FSM state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - Default BASE_ADDR constant, alongside pc_start in ucsbece154b_defines.vh.
- One sub-module: ucsbece154b_dmem_array.
  - DEPTH_WORDS x 32 storage.
  - Synchronous byte-enable write port and asynchronous read port.
  - The FSM controls it via a single commit strobe.

Test Plan:
- Reset during RESP, then release: resp_valid_o drops to 0 immediately and req_ready_o=1. Pending read data is discarded; the next read of 0x10000000 with WAIT_CYCLES=2 returns valid data 3 cycles after acceptance.
- Write 0x10000004 data 0xAABBCCDD be 4'b1111, then read it back: ack with err 0. Read returns 0xAABBCCDD after 3 cycles (WAIT_CYCLES=2).
- Write 0x10000004 data 0x11223344 be 4'b0101 over 0xAABBCCDD: read back 0xAA22CC44.
- Read 0x10000006 (misaligned) and read 0x0FFFFFFC (below base): both give err 1 and rdata 0. A subsequent read of 0x10000004 shows storage unchanged.
- resp_ready_i held 0 for 5 cycles in RESP: resp_valid_o stays 1 and rdata stays stable throughout; req_ready_o stays 0 even if req_valid_i=1.
- WAIT_CYCLES=0 build, reads back-to-back with resp_ready_i=1: one response every 2 cycles. Last word index DEPTH_WORDS-1 is accessible; index DEPTH_WORDS gives err.
